// File: rtl/pid_pkg.sv
// Shared types and sign-magnitude helpers for the PID controller.
package pid_pkg;

  localparam int          SM_W     = 32;
  localparam int          SIGN_BIT = 31;
  localparam logic [30:0] MAG_MAX  = 31'h7FFF_FFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P    = 3'd1,
    INT  = 3'd2,
    I    = 3'd3,
    D    = 3'd4,
    SUM  = 3'd5
  } state_t;

  // A negative zero collapses to +0 so downstream logic only sees canonical values.
  function automatic logic [SM_W-1:0] sm_canon(input logic [SM_W-1:0] a);
    return {a[SIGN_BIT] & (|a[SIGN_BIT-1:0]), a[SIGN_BIT-1:0]};
  endfunction

  function automatic logic [SM_W-1:0] sm_neg(input logic [SM_W-1:0] a);
    return {~a[SIGN_BIT] & (|a[SIGN_BIT-1:0]), a[SIGN_BIT-1:0]};
  endfunction

  function automatic logic [SM_W-1:0] sm_mul_sat(input logic [SM_W-1:0] a,
                                                  input logic [SM_W-1:0] b);
    logic [61:0] prod;
    logic [30:0] mag;
    logic        sgn;
    prod = {31'd0, a[SIGN_BIT-1:0]} * {31'd0, b[SIGN_BIT-1:0]};
    mag  = (|prod[61:31]) ? MAG_MAX : prod[30:0];
    sgn  = (a[SIGN_BIT] ^ b[SIGN_BIT]) & (|mag);
    return {sgn, mag};
  endfunction

endpackage

// File: rtl/add32.sv
// Combinational sign-magnitude adder; overflow flags a carry out of the magnitude.
module add32
  import pid_pkg::*;
(
  input  logic [SM_W-1:0] num1,
  input  logic [SM_W-1:0] num2,
  output logic [SM_W-1:0] sum,
  output logic            overflow
);

  logic [30:0] m1;
  logic [30:0] m2;
  logic [30:0] mag;
  logic [31:0] mag_add;
  logic        s1;
  logic        s2;
  logic        sgn;

  // Same signs add magnitudes; opposite signs subtract the smaller from the larger.
  always_comb begin
    m1       = num1[SIGN_BIT-1:0];
    m2       = num2[SIGN_BIT-1:0];
    s1       = num1[SIGN_BIT] & (|m1);
    s2       = num2[SIGN_BIT] & (|m2);
    mag_add  = {1'b0, m1} + {1'b0, m2};
    mag      = mag_add[30:0];
    sgn      = s1;
    overflow = 1'b0;
    if (s1 == s2) begin
      overflow = mag_add[31];
    end else if (m1 >= m2) begin
      mag = m1 - m2;
      sgn = s1;
    end else begin
      mag = m2 - m1;
      sgn = s2;
    end
    sum = {sgn & (|mag), mag};
  end

endmodule

// File: rtl/pid_controller.sv
// Sequential sign-magnitude PID controller: one term per state, one shared
// multiplier, two add32 instances, saturating arithmetic throughout.
module pid_controller
  import pid_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         start_calc,
  input  logic [W-1:0] error,
  input  logic [W-1:0] Kp,
  input  logic [W-1:0] Ki,
  input  logic [W-1:0] Kd,
  input  logic [W-1:0] delta_t,
  output logic [W-1:0] PID_out,
  output logic         done
);

  state_t          state_q, state_d;
  logic [SM_W-1:0] e_cur_q, e_cur_d;
  logic [SM_W-1:0] e_prev_q, e_prev_d;
  logic [SM_W-1:0] integ_q, integ_d;
  logic [SM_W-1:0] p_term_q, p_term_d;
  logic [SM_W-1:0] i_term_q, i_term_d;
  logic [SM_W-1:0] d_term_q, d_term_d;
  logic [SM_W-1:0] pid_out_q, pid_out_d;
  logic            done_q, done_d;

  logic [SM_W-1:0] a_num1, a_num2, a_sum, a_sat;
  logic [SM_W-1:0] b_num1, b_num2, b_sum, b_sat;
  logic [SM_W-1:0] mul_a, mul_b, mul_res;
  logic            a_ovf, b_ovf;

  add32 u_add_a (.num1(a_num1), .num2(a_num2), .sum(a_sum), .overflow(a_ovf));
  add32 u_add_b (.num1(b_num1), .num2(b_num2), .sum(b_sum), .overflow(b_ovf));

  // On overflow both operands share a nonzero sign, so num1's sign is the result's.
  always_comb begin
    a_sat = a_ovf ? {a_num1[SIGN_BIT], MAG_MAX} : a_sum;
    b_sat = b_ovf ? {b_num1[SIGN_BIT], MAG_MAX} : b_sum;
  end

  // Adder B only sees registers, so it can feed both the multiplier and adder A without a loop.
  always_comb begin
    b_num1 = {SM_W{1'b0}};
    b_num2 = {SM_W{1'b0}};
    case (state_q)
      D: begin
        b_num1 = e_cur_q;
        b_num2 = sm_neg(e_prev_q);
      end
      SUM: begin
        b_num1 = p_term_q;
        b_num2 = i_term_q;
      end
      default: begin
        b_num1 = {SM_W{1'b0}};
        b_num2 = {SM_W{1'b0}};
      end
    endcase
  end

  // Shared multiplier operand selection.
  always_comb begin
    mul_a = {SM_W{1'b0}};
    mul_b = {SM_W{1'b0}};
    case (state_q)
      P: begin
        mul_a = Kp;
        mul_b = e_cur_q;
      end
      INT: begin
        mul_a = e_cur_q;
        mul_b = delta_t;
      end
      I: begin
        mul_a = Ki;
        mul_b = integ_q;
      end
      D: begin
        mul_a = Kd;
        mul_b = b_sat;
      end
      default: begin
        mul_a = {SM_W{1'b0}};
        mul_b = {SM_W{1'b0}};
      end
    endcase
    mul_res = sm_mul_sat(mul_a, mul_b);
  end

  // Adder A: integrator update, and the final stage of the output sum.
  always_comb begin
    a_num1 = {SM_W{1'b0}};
    a_num2 = {SM_W{1'b0}};
    case (state_q)
      INT: begin
        a_num1 = integ_q;
        a_num2 = mul_res;
      end
      SUM: begin
        a_num1 = b_sat;
        a_num2 = d_term_q;
      end
      default: begin
        a_num1 = {SM_W{1'b0}};
        a_num2 = {SM_W{1'b0}};
      end
    endcase
  end

  // Sequencer next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    e_cur_d   = e_cur_q;
    e_prev_d  = e_prev_q;
    integ_d   = integ_q;
    p_term_d  = p_term_q;
    i_term_d  = i_term_q;
    d_term_d  = d_term_q;
    pid_out_d = pid_out_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_calc) begin
          e_cur_d = sm_canon(error);
          state_d = P;
        end else begin
          state_d = IDLE;
        end
      end
      P: begin
        p_term_d = mul_res;
        state_d  = INT;
      end
      INT: begin
        integ_d = a_sat;
        state_d = I;
      end
      I: begin
        i_term_d = mul_res;
        state_d  = D;
      end
      D: begin
        d_term_d = mul_res;
        state_d  = SUM;
      end
      SUM: begin
        pid_out_d = a_sat;
        e_prev_d  = e_cur_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset wins over the clock enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      e_cur_q   <= {SM_W{1'b0}};
      e_prev_q  <= {SM_W{1'b0}};
      integ_q   <= {SM_W{1'b0}};
      p_term_q  <= {SM_W{1'b0}};
      i_term_q  <= {SM_W{1'b0}};
      d_term_q  <= {SM_W{1'b0}};
      pid_out_q <= {SM_W{1'b0}};
      done_q    <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      e_cur_q   <= e_cur_d;
      e_prev_q  <= e_prev_d;
      integ_q   <= integ_d;
      p_term_q  <= p_term_d;
      i_term_q  <= i_term_d;
      d_term_q  <= d_term_d;
      pid_out_q <= pid_out_d;
      done_q    <= done_d;
    end
  end

  assign PID_out = pid_out_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pid_controller.sv
// Scoreboard bench for pid_controller: an integer reference model pushes the
// expected output on each request and a monitor pops it when done pulses.
module tb_pid_controller;

  localparam longint MAXV = 64'sd2147483647;

  logic        clk = 1'b0;
  logic        rst, en, start_calc, done;
  logic [31:0] error, Kp, Ki, Kd, delta_t, PID_out;

  always #5 clk = ~clk;

  pid_controller #(.W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .start_calc(start_calc), .error(error),
    .Kp(Kp), .Ki(Ki), .Kd(Kd), .delta_t(delta_t), .PID_out(PID_out), .done(done)
  );

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];
  longint      m_integ = 0;
  longint      m_eprev = 0;
  bit          mon_ovf = 1'b0;
  bit          ovf_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > MAXV) return MAXV;
    if (v < -MAXV) return -MAXV;
    return v;
  endfunction

  function automatic longint sm2i(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] i2sm(input longint v);
    if (v < 0) return {1'b1, 31'(-v)};
    return {1'b0, 31'(v)};
  endfunction

  task automatic model_push(input logic [31:0] e);
    longint ec, p, i, d;
    ec      = sm2i(e);
    p       = clamp(sm2i(Kp) * ec);
    m_integ = clamp(m_integ + clamp(ec * sm2i(delta_t)));
    i       = clamp(sm2i(Ki) * m_integ);
    d       = clamp(sm2i(Kd) * clamp(ec - m_eprev));
    m_eprev = ec;
    exp_q.push_back(i2sm(clamp(clamp(p + i) + d)));
  endtask

  task automatic model_reset();
    m_integ = 0;
    m_eprev = 0;
    exp_q.delete();
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      check_eq("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check_eq("pid_out", PID_out, exp_q.pop_front());
    end
    if (mon_ovf && ((dut.u_add_a.overflow === 1'b1) || (dut.u_add_b.overflow === 1'b1)))
      ovf_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one request at a negedge and wait (bounded) for done.
  task automatic run_calc(input logic [31:0] e, input int gap_at, input int gap_len,
                          input bit hold, input int exp_lat);
    int lat;
    error      = e;
    start_calc = 1'b1;
    model_push(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !hold) start_calc = 1'b0;
      if (gap_len > 0 && lat == gap_at) en = 1'b0;
      if (gap_len > 0 && lat == gap_at + gap_len) en = 1'b1;
    end while (done !== 1'b1 && lat < 40);
    start_calc = 1'b0;
    en         = 1'b1;
    check_eq("latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int     cnt;
    longint pos, sp, e;
    logic [31:0] e0;
    rst = 1'b1; en = 1'b1; start_calc = 1'b1;
    error = 32'd0; Kp = 32'd0; Ki = 32'd0; Kd = 32'd0; delta_t = 32'd0;

    // Reset with start held high must not launch anything.
    tick(3);
    rst = 1'b0; start_calc = 1'b0;
    tick(1);
    check_eq("rst_pid_out", PID_out, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    tick(8);
    check_eq("rst_no_done", 32'(done_cnt), 32'd0);

    Kp = 32'd10; Ki = 32'd1; Kd = 32'd1; delta_t = 32'd1;
    run_calc({1'b1, 31'd905000}, 0, 0, 1'b0, 6);
    check_eq("first_value", PID_out, 32'h80A5_B5E0);
    tick(1);
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);
    run_calc({1'b1, 31'd905000}, 0, 0, 1'b0, 6);
    check_eq("second_value", PID_out, 32'h80A5_B5E0);

    // Back-to-back: the next request lands on the done cycle.
    run_calc({1'b0, 31'd1000}, 0, 0, 1'b0, 6);
    run_calc({1'b1, 31'd300}, 0, 0, 1'b0, 6);
    tick(1);

    Kp = 32'h7FFF_FFFF; Ki = 32'd0; Kd = 32'd0;
    run_calc(32'd2, 0, 0, 1'b0, 6);
    check_eq("sat_pos", PID_out, 32'h7FFF_FFFF);
    run_calc({1'b1, 31'd2}, 0, 0, 1'b0, 6);
    check_eq("sat_neg", PID_out, 32'hFFFF_FFFF);
    tick(1);

    // start held high through a calculation gives a single done.
    Kp = 32'd3; Ki = {1'b1, 31'd2}; Kd = 32'd5; delta_t = 32'd4;
    cnt = done_cnt;
    run_calc(32'd12345, 0, 0, 1'b1, 6);
    tick(10);
    check_eq("hold_one_done", 32'(done_cnt - cnt), 32'd1);

    run_calc({1'b1, 31'd777}, 2, 3, 1'b0, 9);
    tick(1);
    run_calc(32'h8000_0000, 0, 0, 1'b0, 6);
    tick(1);

    // Reset mid-calculation with en low: reset wins and the result is dropped.
    error = 32'd4242; start_calc = 1'b1;
    tick(1);
    start_calc = 1'b0;
    tick(2);
    en = 1'b0; rst = 1'b1;
    tick(2);
    check_eq("abort_pid_out", PID_out, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    rst = 1'b0; en = 1'b1;
    cnt = done_cnt;
    tick(10);
    check_eq("abort_no_done", 32'(done_cnt - cnt), 32'd0);
    model_reset();

    // Closed loop against a simple integrating plant.
    Kp = 32'd10; Ki = 32'd1; Kd = 32'd1; delta_t = 32'd1;
    pos = 5000; sp = -900000;
    e0 = i2sm(sp - pos);
    mon_ovf = 1'b1;
    for (int k = 0; k < 500; k++) begin
      e = sp - pos;
      run_calc(i2sm(e), 0, 0, 1'b0, 6);
      pos = pos + sm2i(PID_out) / 32;
    end
    mon_ovf = 1'b0;
    e = sp - pos;
    check_eq("loop_start_err", e0, {1'b1, 31'd905000});
    check_eq("loop_converged", {31'd0, (e < 9050) && (e > -9050)}, 32'd1);
    check_eq("loop_no_overflow", {31'd0, ovf_seen}, 32'd0);
    tick(2);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pid_controller.md
Name: pid_controller

Overview:
- Sequential PID controller on 32-bit sign-magnitude data: bit 31 is the sign (1 = negative) and bits [30:0] are the magnitude.
- On each `start_calc` request it takes the current error sample and computes P, I and D terms, then the saturated sum.
- It pulses `done` when `PID_out` is valid.
- It sits in the control loop between the error computation (setpoint − position) and the plant/actuator model.

Parameters:
- W, 32, data word width (sign + 31-bit magnitude).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  clock enable; low freezes all registers and the FSM
- start_calc  in  1  request a new calculation; sampled only in IDLE
- error  in  32  sign-magnitude error sample, latched on accept
- Kp  in  32  sign-magnitude proportional gain
- Ki  in  32  sign-magnitude integral gain
- Kd  in  32  sign-magnitude derivative gain
- delta_t  in  32  sign-magnitude timestep, used for integral accumulation
- PID_out  out  32  sign-magnitude controller output, held between calculations
- done  out  1  one-cycle pulse when `PID_out` updates

Behaviour:
- Interface: one clock (`clk`); reset `rst` is synchronous and active-high.
- Reset:
  - `PID_out` = 0, `done` = 0, FSM = IDLE.
  - Integral accumulator = 0, previous error `e_prev` = 0, all term registers = 0.
  - Reset mid-calculation aborts the calculation with the same result.
- `en` = 0: no register changes. `rst` has priority over `en`.
- FSM states: IDLE → P → INT → I → D → SUM → IDLE. One state per clock.
  - IDLE: if `start_calc` = 1, latch `error` into `e_cur` and go to P. Otherwise stay. `start_calc` outside IDLE is ignored (no queueing).
  - P: `p_term` = smul(`Kp`, `e_cur`).
  - INT: `integ` = sadd(`integ`, smul(`e_cur`, `delta_t`)).
  - I: `i_term` = smul(`Ki`, `integ`).
  - D: `d_term` = smul(`Kd`, sadd(`e_cur`, −`e_prev`)).
    - There is no division by `delta_t`; the caller folds the timestep into `Kd`.
  - SUM: `PID_out` = sadd(sadd(`p_term`, `i_term`), `d_term`); `e_prev` = `e_cur`; `done` = 1 for exactly this one registered cycle; return to IDLE.
- Latency:
  - `done` is high during the 6th cycle after the accept edge.
  - A new `start_calc` is accepted on the cycle `done` is high (FSM back in IDLE) or later.
- smul (sign-magnitude multiply):
  - sign = XOR of the input signs.
  - magnitude = 31×31 product; saturate to 0x7FFFFFFF if any bit above bit 30 is set.
- sadd (sign-magnitude saturating add, via add32):
  - If add32 reports overflow, the magnitude becomes 0x7FFFFFFF with the sign of the operands.
  - Negation = sign-bit flip.
- Zero: −0 on any input is treated as +0. All results are canonical: a zero magnitude forces sign = 0.
- The integrator saturates rather than wrapping (anti-windup by clamp).

Decomposition:
- Package pid_pkg:
  - SM_W = 32, SIGN_BIT = 31, MAG_MAX = 31'h7FFF_FFFF.
  - FSM state enum {IDLE, P, INT, I, D, SUM}.
  - Functions sm_mul_sat and sm_neg.
- Sub-module add32 (combinational sign-magnitude adder).
  - Ports: `num1`[31:0], `num2`[31:0], `sum`[31:0], `overflow`.
  - Same signs: add magnitudes, keep the sign; `overflow` is the carry out of bit 30.
  - Different signs: subtract the smaller magnitude from the larger and take the larger operand's sign; `overflow` = 0.
  - `sum` carries the wrapped low 31 bits; zero results are +0.
- pid_controller instantiates add32 for all additions.
- One shared multiplier is used per state.

Test Plan:
- Reset state: reset, then en=1 → `PID_out`=0, `done`=0; `start_calc` pulsed while `rst`=1 gives no `done`.
- First calculation:
  - Inputs: `Kp`=10, `Ki`=1, `Kd`=1, `delta_t`=1, `error`={1, 905000}.
  - Required: P=−9050000, I=−905000, D=−905000.
  - `PID_out`={1, 10860000}; `done` pulses exactly one cycle, 6 cycles after accept.
- Second calculation with the same error:
  - integ=−1810000, I=−1810000, D=0.
  - `PID_out`={1, 10860000}.
- Saturation: `Kp`=0x7FFFFFFF, `error`=2, `Ki`=`Kd`=0 → `PID_out`=0x7FFFFFFF.
  - Same with `error`={1, 2} → `PID_out`=0xFFFFFFFF.
- Handshake and enable:
  - `start_calc` held high through a calculation → exactly one `done` per IDLE acceptance.
  - `en`=0 mid-calculation for 3 cycles → `done` delayed by exactly 3 cycles, result unchanged.
- Closed loop:
  - Setup: position=5000, setpoint={1, 900000}; each cycle position += `PID_out`/32 and error = setpoint − position.
  - Run 500 iterations.
  - Required: error magnitude converges toward 0, no X values, add32 `overflow` never set.
